// File: rtl/secam_pkg.sv
// Shared types, rest-period constants and the s8 saturation helper for the
// SECAM chroma FM demodulator.
package secam_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    MEASURE
  } dec_state_e;

  localparam int NOM_DB_DEF = 181;
  localparam int NOM_DR_DEF = 174;
  localparam int PROD_W     = 24;

  function automatic logic signed [7:0] sat_s8(input logic signed [PROD_W-1:0] x);
    if (x > 24'sd127) begin
      return 8'sd127;
    end else if (x < -24'sd128) begin
      return -8'sd128;
    end else begin
      return x[7:0];
    end
  endfunction

endpackage

// File: rtl/secam_zero_cross_detector.sv
// Hysteresis zero-crossing detector: arms below -HYST, fires once at or above
// +HYST, and flags a timeout when no crossing is seen for TIMEOUT clocks.
module secam_zero_cross_detector
  import secam_pkg::*;
#(
  parameter int HYST    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic signed [7:0] chroma,
  output logic              xing,
  output logic              timeout
);

  localparam int GAP_W = $clog2(TIMEOUT + 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(TIMEOUT);
  // Fire one clock early so the registered carrier_lost lands TIMEOUT clocks after the crossing.
  localparam logic [GAP_W-1:0] GAP_FIRE = GAP_W'(TIMEOUT - 1);
  localparam logic signed [7:0] HYST_S = 8'(HYST);

  logic armed_q, armed_d;
  logic xing_q, xing_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  always_comb begin
    xing_d  = armed_q && (chroma >= HYST_S);
    armed_d = armed_q;
    if (xing_d) begin
      armed_d = 1'b0;
    end else if (chroma <= -HYST_S) begin
      armed_d = 1'b1;
    end
    if (xing_d) begin
      gap_d = '0;
    end else if (gap_q == GAP_MAX) begin
      gap_d = gap_q;
    end else begin
      gap_d = gap_q + 1'b1;
    end
    if (clear) begin
      armed_d = 1'b0;
      xing_d  = 1'b0;
      gap_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b0;
      xing_q  <= 1'b0;
      gap_q   <= '0;
    end else begin
      armed_q <= armed_d;
      xing_q  <= xing_d;
      gap_q   <= gap_d;
    end
  end

  assign xing    = xing_q;
  assign timeout = (gap_q == GAP_FIRE);

endmodule

// File: rtl/secam_decoder.sv
// SECAM chroma FM demodulator: measures the carrier period over CYCLES_PER_MEAS
// cycles and converts the deviation to signed U/V. Optional SECAM_DEEMPHASIS_EN.
module secam_decoder
  import secam_pkg::*;
#(
  parameter int COUNT_W         = 12,
  parameter int CYCLES_PER_MEAS = 16,
  parameter int NOM_DB          = NOM_DB_DEF,
  parameter int NOM_DR          = NOM_DR_DEF,
  parameter int GAIN            = 8,
  parameter int HYST            = 4,
  parameter int TIMEOUT         = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enabled,
  input  logic              even_line,
  input  logic signed [7:0] chroma,
  output logic signed [7:0] yuv_u,
  output logic signed [7:0] yuv_v,
  output logic              out_valid,
  output logic              carrier_lost
);

  localparam int CYC_W = $clog2(CYCLES_PER_MEAS);
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CYCLES_PER_MEAS - 1);
  localparam logic signed [COUNT_W:0] NOM_DB_S = (COUNT_W + 1)'(NOM_DB);
  localparam logic signed [COUNT_W:0] NOM_DR_S = (COUNT_W + 1)'(NOM_DR);
  localparam logic signed [PROD_W-1:0] GAIN_S = PROD_W'(GAIN);

  dec_state_e state_q, state_d;
  logic [COUNT_W-1:0] period_cnt_q, period_cnt_d;
  logic [CYC_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic line_q, line_d;
  logic carrier_lost_q, carrier_lost_d;
  logic signed [PROD_W-1:0] prod_q, prod_d;
  logic prod_vld_q, prod_vld_d;
  logic prod_u_q, prod_u_d;
  logic signed [7:0] yuv_u_q, yuv_u_d, yuv_v_q, yuv_v_d;
  logic out_valid_q, out_valid_d;

  logic xing, timeout;
  logic signed [COUNT_W:0] dev;
  logic signed [PROD_W-1:0] dev_ext, mag;
  logic signed [PROD_W-1:0] stage_val;
  logic stage_vld, stage_u;

  secam_zero_cross_detector #(
    .HYST    (HYST),
    .TIMEOUT (TIMEOUT)
  ) u_zero_cross (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_q == IDLE),
    .chroma  (chroma),
    .xing    (xing),
    .timeout (timeout)
  );

  always_comb begin
    state_d        = state_q;
    period_cnt_d   = period_cnt_q;
    cycle_cnt_d    = cycle_cnt_q;
    line_d         = line_q;
    carrier_lost_d = carrier_lost_q;
    prod_d         = prod_q;
    prod_u_d       = prod_u_q;
    prod_vld_d     = 1'b0;
    dev     = $signed({1'b0, period_cnt_q}) - (line_q ? NOM_DB_S : NOM_DR_S);
    dev_ext = {{(PROD_W - COUNT_W - 1){dev[COUNT_W]}}, dev};
    mag     = dev_ext * GAIN_S;

    case (state_q)
      IDLE: begin
        period_cnt_d   = '0;
        cycle_cnt_d    = '0;
        carrier_lost_d = 1'b1;
        if (enabled) state_d = ACQUIRE;
      end
      ACQUIRE: begin
        period_cnt_d = '0;
        cycle_cnt_d  = '0;
        if (xing) begin
          // Start at 1 so the starting crossing clock is counted, same as the back-to-back restart.
          state_d      = MEASURE;
          period_cnt_d = COUNT_W'(1);
          line_d       = even_line;
        end else if (timeout) begin
          carrier_lost_d = 1'b1;
        end
      end
      MEASURE: begin
        if (even_line != line_q) begin
          state_d      = ACQUIRE;
          period_cnt_d = '0;
          cycle_cnt_d  = '0;
        end else begin
          period_cnt_d = (period_cnt_q == CNT_MAX) ? period_cnt_q : period_cnt_q + 1'b1;
          if (xing) begin
            if (cycle_cnt_q == CYC_LAST) begin
              period_cnt_d   = COUNT_W'(1);
              cycle_cnt_d    = '0;
              carrier_lost_d = 1'b0;
              prod_vld_d     = 1'b1;
              prod_u_d       = line_q;
              prod_d         = line_q ? -mag : mag;
            end else begin
              cycle_cnt_d = cycle_cnt_q + 1'b1;
            end
          end else if (timeout) begin
            state_d        = ACQUIRE;
            period_cnt_d   = '0;
            cycle_cnt_d    = '0;
            carrier_lost_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (!enabled) begin
      state_d        = IDLE;
      period_cnt_d   = '0;
      cycle_cnt_d    = '0;
      carrier_lost_d = 1'b1;
      prod_vld_d     = 1'b0;
    end
  end

`ifdef SECAM_DEEMPHASIS_EN
  logic signed [PROD_W-1:0] acc_q, acc_d;
  logic acc_vld_q, acc_vld_d, acc_u_q, acc_u_d;
  logic line_prev_q, line_prev_d;

  // First-order de-emphasis; restarts whenever the line type flips.
  always_comb begin
    acc_d       = acc_q;
    acc_vld_d   = prod_vld_q;
    acc_u_d     = prod_u_q;
    line_prev_d = even_line;
    if (prod_vld_q) acc_d = acc_q + ((prod_q - acc_q) >>> 3);
    if (even_line != line_prev_q) acc_d = '0;
    if (!enabled || state_q == IDLE) begin
      acc_d     = '0;
      acc_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      acc_vld_q   <= 1'b0;
      acc_u_q     <= 1'b0;
      line_prev_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      acc_vld_q   <= acc_vld_d;
      acc_u_q     <= acc_u_d;
      line_prev_q <= line_prev_d;
    end
  end

  assign stage_val = acc_q;
  assign stage_vld = acc_vld_q;
  assign stage_u   = acc_u_q;
`else
  assign stage_val = prod_q;
  assign stage_vld = prod_vld_q;
  assign stage_u   = prod_u_q;
`endif

  always_comb begin
    yuv_u_d     = yuv_u_q;
    yuv_v_d     = yuv_v_q;
    out_valid_d = 1'b0;
    if (stage_vld) begin
      out_valid_d = 1'b1;
      if (stage_u) begin
        yuv_u_d = sat_s8(stage_val);
      end else begin
        yuv_v_d = sat_s8(stage_val);
      end
    end
    if (!enabled || state_q == IDLE) begin
      yuv_u_d     = '0;
      yuv_v_d     = '0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      period_cnt_q   <= '0;
      cycle_cnt_q    <= '0;
      line_q         <= 1'b0;
      carrier_lost_q <= 1'b1;
      prod_q         <= '0;
      prod_vld_q     <= 1'b0;
      prod_u_q       <= 1'b0;
      yuv_u_q        <= '0;
      yuv_v_q        <= '0;
      out_valid_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      period_cnt_q   <= period_cnt_d;
      cycle_cnt_q    <= cycle_cnt_d;
      line_q         <= line_d;
      carrier_lost_q <= carrier_lost_d;
      prod_q         <= prod_d;
      prod_vld_q     <= prod_vld_d;
      prod_u_q       <= prod_u_d;
      yuv_u_q        <= yuv_u_d;
      yuv_v_q        <= yuv_v_d;
      out_valid_q    <= out_valid_d;
    end
  end

  assign yuv_u        = yuv_u_q;
  assign yuv_v        = yuv_v_q;
  assign out_valid    = out_valid_q;
  assign carrier_lost = carrier_lost_q;

endmodule
